// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter and registered 4:1 mux: shares one valid/ready output
// channel among four requesters and holds each captured word until accepted.
// Ports: clk, rst_n (async active-low),
//        req_valid[3:0], req_data[4*DATA_W-1:0], req_ready[3:0] (one-hot/zero),
//        out_valid, out_data[DATA_W-1:0], out_sel[1:0], out_ready.
module rr_mux4_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req_valid,
    input  logic [4*DATA_W-1:0]   req_data,
    output logic [3:0]            req_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_sel,
    input  logic                  out_ready
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        last_q, last_d;

    logic       can_load;
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    logic       load;

    assign can_load = !valid_q || out_ready;

    // Scan last+1 .. last+4 with 2-bit wrap; first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign load = can_load && found;

    // Held at zero during reset so no requester believes a word was taken.
    always_comb begin
        req_ready = 4'b0000;
        if (rst_n && load) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = req_data[win*DATA_W +: DATA_W];
            sel_d   = win;
            last_d  = win;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= 2'b00;
            last_q  <= 2'b11;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter: directed vector table, async
// reset cases and randomized traffic against a behavioural model.
module tb_rr_mux4_arbiter;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      req_valid = 4'h0;
    logic [4*DW-1:0] req_data = '0;
    logic [3:0]      req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_sel;
    logic            out_ready = 1'b0;

    rr_mux4_arbiter #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit      m_ov;
    logic [7:0] m_od;
    int      m_os;
    int      m_ptr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_ov = 1'b0;
        m_od = 8'h00;
        m_os = 0;
        m_ptr = 3;
    endfunction

    function automatic int winner(input logic [3:0] v);
        for (int k = 1; k <= 4; k++)
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input logic [3:0] v,
                                             input bit ordy);
        int w;
        w = winner(v);
        if (w >= 0 && (!m_ov || ordy)) return 4'(1 << w);
        return 4'h0;
    endfunction

    function automatic void model_step(input logic [3:0] v,
                                       input logic [31:0] d, input bit ordy);
        int w;
        w = winner(v);
        if (w >= 0 && (!m_ov || ordy)) begin
            m_ov = 1'b1;
            m_od = d[w*8 +: 8];
            m_os = w;
            m_ptr = w;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
    endfunction

    // One clock: drive at negedge, sample ready, update at posedge.
    task automatic cycle(input logic [3:0] v, input logic [31:0] d,
                         input bit ordy, input bit use_model,
                         output logic [3:0] rdy);
        @(negedge clk);
        req_valid = v;
        req_data = d;
        out_ready = ordy;
        #1;
        rdy = req_ready;
        if (use_model) chk("rnd ready", req_ready, exp_ready(v, ordy));
        @(posedge clk);
        model_step(v, d, ordy);
        #1;
        if (use_model) begin
            chk("rnd out_valid", out_valid, m_ov);
            chk("rnd out_data", out_data, m_od);
            chk("rnd out_sel", out_sel, m_os[1:0]);
        end
    endtask

    typedef struct {
        logic [3:0] v;
        bit         ordy;
        logic [3:0] er;
        bit         eov;
        logic [1:0] esel;
        logic [7:0] edat;
    } vec_t;

    vec_t vec[18];
    logic [3:0] rdy;
    logic [31:0] wd;

    initial begin
        wd = 32'hD3C2B1A0;
        vec[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        vec[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};
        vec[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2};
        vec[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
        vec[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        vec[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};
        vec[6]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hB1};
        vec[7]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hB1};
        vec[8]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hB1};
        vec[9]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2};
        vec[10] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
        vec[11] = '{4'h4, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2};
        vec[12] = '{4'h3, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        vec[13] = '{4'h3, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};
        vec[14] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd1, 8'hB1};
        vec[15] = '{4'h0, 1'b0, 4'b0000, 1'b0, 2'd1, 8'hB1};
        vec[16] = '{4'h2, 1'b0, 4'b0010, 1'b1, 2'd1, 8'hB1};
        vec[17] = '{4'h1, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hB1};

        // Reset with all requesters asserting
        model_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        req_data = wd;
        out_ready = 1'b1;
        #3;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_sel", out_sel, 2'd0);
        chk("reset out_data", out_data, 8'h00);
        chk("reset req_ready", req_ready, 4'h0);
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cycle(vec[i].v, wd, vec[i].ordy, 1'b0, rdy);
            chk($sformatf("vec%0d ready", i), rdy, vec[i].er);
            chk($sformatf("vec%0d out_valid", i), out_valid, vec[i].eov);
            chk($sformatf("vec%0d out_sel", i), out_sel, vec[i].esel);
            chk($sformatf("vec%0d out_data", i), out_data, vec[i].edat);
        end

        // Async reset mid-stall (holding B1, out_ready low)
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 1'b0);
        chk("midrst req_ready", req_ready, 4'h0);
        chk("midrst out_sel", out_sel, 2'd0);
        chk("midrst out_data", out_data, 8'h00);
        model_reset();
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'hF, wd, 1'b1, 1'b0, rdy);
        chk("post-rst ready", rdy, 4'b0001);
        chk("post-rst out_sel", out_sel, 2'd0);
        chk("post-rst out_data", out_data, 8'hA0);
        model_step(4'h0, wd, 1'b0);
        m_ov = 1'b1; m_od = 8'hA0; m_os = 0; m_ptr = 0;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(4'($urandom), $urandom, ($urandom_range(0, 3) != 0),
                  1'b1, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
